// File: rtl/borrow_skip_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module   : borrow_skip_subtractor_seq
// Function : Multi-cycle a - b - bin, one BLOCK-bit slice per clock, LSB first,
//            with a per-slice borrow-skip path and valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module borrow_skip_subtractor_seq #(
    parameter int  WIDTH = 16,
    parameter int  BLOCK = 4,
    localparam int c_N   = WIDTH / BLOCK,
    localparam int c_CW  = $clog2(c_N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  diff,
    output logic              bout,
    output logic [c_CW-1:0]   skip_count
);

    localparam int c_KW = (c_N > 1) ? $clog2(c_N) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_borrow;
    logic [c_CW-1:0]  r_skip_count;
    logic [c_KW-1:0]  r_k;

    logic [BLOCK-1:0] w_a_sl;
    logic [BLOCK-1:0] w_b_sl;
    logic [BLOCK-1:0] w_d;
    logic             w_ripple_bout;
    logic             w_skip;
    logic             w_slice_bout;
    logic             w_last;
    logic             w_accept;

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)  w_next_state = c_RUN;
            c_RUN:   if (w_last)    w_next_state = c_DONE;
            c_DONE:  if (out_ready) w_next_state = c_IDLE;
            default:                w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_k == c_KW'(c_N - 1));

    // ------------------------------------------------------------------
    // Slice datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int s = 0; s < c_N; s++) begin
            if (r_k == c_KW'(s)) begin
                w_a_sl = r_a[s*BLOCK +: BLOCK];
                w_b_sl = r_b[s*BLOCK +: BLOCK];
            end
        end
    end

    always_comb begin : p_ripple
        logic v_br;
        v_br = r_borrow;
        w_d  = '0;
        for (int i = 0; i < BLOCK; i++) begin
            w_d[i] = w_a_sl[i] ^ w_b_sl[i] ^ v_br;
            v_br   = (~w_a_sl[i] & w_b_sl[i]) | (~(w_a_sl[i] ^ w_b_sl[i]) & v_br);
        end
        w_ripple_bout = v_br;
    end

    // Equal bit pairs everywhere mean the slice just passes its borrow-in through.
    assign w_skip       = &(~(w_a_sl ^ w_b_sl));
    assign w_slice_bout = w_skip ? r_borrow : w_ripple_bout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_diff       <= '0;
            r_bout       <= 1'b0;
            r_borrow     <= 1'b0;
            r_skip_count <= '0;
            r_k          <= '0;
        end else if (w_accept) begin
            r_a          <= a;
            r_b          <= b;
            r_diff       <= '0;
            r_bout       <= 1'b0;
            r_borrow     <= bin;
            r_skip_count <= '0;
            r_k          <= '0;
        end else if (r_state == c_RUN) begin
            for (int s = 0; s < c_N; s++) begin
                if (r_k == c_KW'(s)) begin
                    r_diff[s*BLOCK +: BLOCK] <= w_d;
                end
            end
            r_borrow <= w_slice_bout;
            r_k      <= r_k + c_KW'(1);
            if (w_skip) begin
                r_skip_count <= r_skip_count + c_CW'(1);
            end
            if (w_last) begin
                r_bout <= w_slice_bout;
            end
        end
    end

    assign diff       = r_diff;
    assign bout       = r_bout;
    assign skip_count = r_skip_count;

endmodule
`default_nettype wire

// File: tb/tb_borrow_skip_subtractor_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_borrow_skip_subtractor_seq
// Function : Directed vector table, handshake/reset corner sequences and a
//            random regression against an a - b - bin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_borrow_skip_subtractor_seq;

    localparam int c_WIDTH = 16;
    localparam int c_BLOCK = 4;
    localparam int c_N     = c_WIDTH / c_BLOCK;
    localparam int c_CW    = $clog2(c_N + 1);
    localparam int c_NRAND = 4000;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [c_WIDTH-1:0]  a;
    logic [c_WIDTH-1:0]  b;
    logic                bin;
    logic                out_valid;
    logic                out_ready;
    logic [c_WIDTH-1:0]  diff;
    logic                bout;
    logic [c_CW-1:0]     skip_count;

    int checks;
    int failures;

    borrow_skip_subtractor_seq #(
        .WIDTH (c_WIDTH),
        .BLOCK (c_BLOCK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .bout       (bout),
        .skip_count (skip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic [2:0]  skip;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents operands for exactly the accept edge.
    task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        bin      = vbin;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] ed,
                                input logic eb, input logic [2:0] es);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_skip"}, 32'(skip_count), 32'(es));
    endtask

    initial begin
        int          lat;
        logic [15:0] ra, rb, mask;
        logic        rbin;
        logic [16:0] full;
        logic [2:0]  rskip;
        int          hold;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 16'h5555;
        b         = 16'h1111;
        bin       = 1'b0;

        vecs[0] = '{a:16'h1234, b:16'h0234, bin:1'b0, diff:16'h1000, bout:1'b0, skip:3'd3};
        vecs[1] = '{a:16'h0000, b:16'h0001, bin:1'b0, diff:16'hFFFF, bout:1'b1, skip:3'd3};
        vecs[2] = '{a:16'hABCD, b:16'hABCD, bin:1'b1, diff:16'hFFFF, bout:1'b1, skip:3'd4};
        vecs[3] = '{a:16'hFFFF, b:16'h0000, bin:1'b1, diff:16'hFFFE, bout:1'b0, skip:3'd0};

        // Reset with in_valid high: nothing may be accepted.
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),   32'd1);
        chk("rst_out_valid", 32'(out_valid),  32'd0);
        chk("rst_diff",      32'(diff),       32'd0);
        chk("rst_bout",      32'(bout),       32'd0);
        chk("rst_skip",      32'(skip_count), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();

        // Directed vector table
        for (int v = 0; v < 4; v++) begin
            start_op(vecs[v].a, vecs[v].b, vecs[v].bin);
            chk($sformatf("vec%0d_busy", v), 32'(in_ready), 32'd0);
            wait_done(lat);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(c_N));
            check_result($sformatf("vec%0d", v), vecs[v].diff, vecs[v].bout, vecs[v].skip);
            release_out();
            chk($sformatf("vec%0d_idle", v), 32'(in_ready), 32'd1);
        end

        // Back-pressure in DONE with new operands waiting
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_done(lat);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'h0000;
        bin      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            check_result("bp_hold", 16'h1000, 1'b0, 3'd3);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_in_ready",  32'(in_ready),  32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("bp_accepted", 32'(in_ready), 32'd0);
        wait_done(lat);
        chk("bp_latency", 32'(lat), 32'(c_N));
        check_result("bp_pending", 16'hFFFE, 1'b0, 3'd0);
        release_out();

        // Reset during the second RUN cycle
        start_op(16'h1234, 16'h0234, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready",  32'(in_ready),   32'd1);
        chk("mid_rst_out_valid", 32'(out_valid),  32'd0);
        chk("mid_rst_diff",      32'(diff),       32'd0);
        chk("mid_rst_skip",      32'(skip_count), 32'd0);
        start_op(16'h0010, 16'h0001, 1'b0);
        wait_done(lat);
        chk("post_rst_latency", 32'(lat), 32'(c_N));
        check_result("post_rst", 16'h000F, 1'b0, 3'd2);
        release_out();

        // Random regression with per-slice equality bias and back-pressure
        for (int r = 0; r < c_NRAND; r++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            mask = 16'($urandom);
            rbin = 1'($urandom);
            for (int s = 0; s < c_N; s++) begin
                if (mask[s]) rb[s*4 +: 4] = ra[s*4 +: 4];
            end
            full  = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
            rskip = 3'd0;
            for (int s = 0; s < c_N; s++) begin
                if (ra[s*4 +: 4] == rb[s*4 +: 4]) rskip = rskip + 3'd1;
            end
            start_op(ra, rb, rbin);
            wait_done(lat);
            chk("rnd_latency", 32'(lat), 32'(c_N));
            check_result("rnd", full[15:0], full[16], rskip);
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("rnd_hold_valid", 32'(out_valid), 32'd1);
                chk("rnd_hold_diff",  32'(diff),      32'(full[15:0]));
            end
            release_out();
            chk("rnd_idle", 32'(in_ready), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
